fpr_mult_unit: RTL and testbench

//  Iterative shift-add integer multiplier (DLX mult/multu) operating on FP-register operands.

---
 rtl/fpr_mult_unit_if.sv | 43 ++++
 rtl/fpr_mult_unit.sv | 120 ++++++++++++
 tb/tb_fpr_mult_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fpr_mult_unit_if.sv
// ---------------------------------------------------------------------------
// fpr_mult_unit_if
// Bundle between the DLX control path / FP register file and the iterative
// multiplier.
//
// Handshake: start is a one-cycle launch request that is only honoured while
// busy is low; once accepted, busy stays high until the cycle after the
// single-cycle done/regWr pulse, and every start seen while busy is dropped.
//
// Signals
//   start, isSigned, opA, opB, rdIn : request side (master -> slave)
//   busy, done, regWr, Rw, busW     : status / regfile write port (slave -> master)
//   productHi                       : high product word, observe only
//   dbg_state                       : registered FSM state, observe only
// Modports: master (requester / bench), slave (multiplier unit)
// ---------------------------------------------------------------------------
interface fpr_mult_unit_if #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  start;
    logic                  isSigned;
    logic [WIDTH-1:0]      opA;
    logic [WIDTH-1:0]      opB;
    logic [REG_ADDR_W-1:0] rdIn;
    logic                  busy;
    logic                  done;
    logic                  regWr;
    logic [REG_ADDR_W-1:0] Rw;
    logic [WIDTH-1:0]      busW;
    logic [WIDTH-1:0]      productHi;
    logic [1:0]            dbg_state;

    modport master (
        output start, isSigned, opA, opB, rdIn,
        input  busy, done, regWr, Rw, busW, productHi, dbg_state
    );

    modport slave (
        input  start, isSigned, opA, opB, rdIn,
        output busy, done, regWr, Rw, busW, productHi, dbg_state
    );
endinterface

// File: rtl/fpr_mult_unit.sv
// ---------------------------------------------------------------------------
// fpr_mult_unit
// Radix-2 shift-add integer multiplier (DLX mult / multu) on FP-register
// operands. One multiplier bit is retired per clock through a single 2*WIDTH
// adder; the low product word is written back through the regfile port.
//
// Ports
//   clk   : system clock, rising-edge state updates
//   reset : asynchronous, active-high
//   bus   : fpr_mult_unit_if.slave (request, regfile write port, debug state)
//
// Configuration
//   MULT_EARLY_TERM_EN : when defined, RUN also ends as soon as the remaining
//                        multiplier bits are all zero. Results are unchanged,
//                        only latency shrinks. Undefined: fixed WIDTH-cycle RUN.
// ---------------------------------------------------------------------------
module fpr_mult_unit #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    fpr_mult_unit_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [1:0]            state;
    logic [2*WIDTH-1:0]    acc;
    logic [2*WIDTH-1:0]    mcand;     // multiplicand, pre-shifted by count
    logic [WIDTH-1:0]      mplier;    // remaining multiplier bits, LSB next
    logic [CNT_W-1:0]      count;
    logic                  neg;
    logic [REG_ADDR_W-1:0] rw_q;
    logic [WIDTH-1:0]      lo_q;
    logic [WIDTH-1:0]      hi_q;

    logic [WIDTH-1:0]      mag_a;
    logic [WIDTH-1:0]      mag_b;
    logic [2*WIDTH-1:0]    fix_val;
    logic                  run_last;

    // Magnitudes for signed operands. The most negative value maps onto
    // itself, which read as unsigned is exactly 2^(WIDTH-1).
    assign mag_a = (bus.isSigned && bus.opA[WIDTH-1]) ? (~bus.opA + WIDTH'(1)) : bus.opA;
    assign mag_b = (bus.isSigned && bus.opB[WIDTH-1]) ? (~bus.opB + WIDTH'(1)) : bus.opB;

    // Sign restore over the full double-width product (modulo 2^(2*WIDTH)).
    assign fix_val = neg ? (~acc + (2*WIDTH)'(1)) : acc;

`ifdef MULT_EARLY_TERM_EN
    // Stop once the bits still to be shifted in are all zero.
    assign run_last = (count == LAST) || (mplier[WIDTH-1:1] == '0);
`else
    assign run_last = (count == LAST);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            neg    <= 1'b0;
            rw_q   <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        rw_q   <= bus.rdIn;
                        neg    <= bus.isSigned & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    if (run_last) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    acc   <= fix_val;
                    lo_q  <= fix_val[WIDTH-1:0];
                    hi_q  <= fix_val[2*WIDTH-1:WIDTH];
                    state <= S_WB;
                end
                default: begin
                    // S_WB: the regfile commits during this cycle.
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_WB);
    assign bus.regWr     = (state == S_WB);
    assign bus.Rw        = rw_q;
    assign bus.busW      = lo_q;
    assign bus.productHi = hi_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_fpr_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_fpr_mult_unit
// Directed bench for fpr_mult_unit: driver tasks issue operations and push
// the hand-computed result, destination and completion cycle into exp_q; a
// negedge monitor pops one entry per regWr pulse and compares.
// ---------------------------------------------------------------------------
module tb_fpr_mult_unit;
    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int EXP_W = 32 + AW + 2 * W;  // {done_cyc, rw, hi, lo}
`ifdef MULT_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;  // number of rising edges so far
    always @(posedge clk) cyc++;

    fpr_mult_unit_if #(.WIDTH(W), .REG_ADDR_W(AW)) bus ();

    fpr_mult_unit #(.WIDTH(W), .REG_ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected rising edges from E0 to the edge that enters WB.
    function automatic int exp_lat(input logic [31:0] b, input logic s);
        logic [31:0] m;
        int k;
        m = (s && b[31]) ? (~b + 32'd1) : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i;
        return EARLY ? (k + 2) : 33;
    endfunction

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (bus.regWr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_wr: got regWr with Rw=%0d, expected no write", bus.Rw);
            end else begin
                e = exp_q.pop_front();
                check("wb_rw",   64'(bus.Rw),        64'(e[68:64]));
                check("wb_lo",   64'(bus.busW),      64'(e[31:0]));
                check("wb_hi",   64'(bus.productHi), 64'(e[63:32]));
                check("wb_cyc",  64'(cyc),           64'(e[100:69]));
                check("wb_done", 64'(bus.done),      64'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called on a negedge; returns on the negedge after E0 with e0 = index of E0.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int e0);
        bus.start    = 1'b1;
        bus.isSigned = s;
        bus.opA      = a;
        bus.opB      = b;
        bus.rdIn     = rd;
        e0 = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        // Operands must not be re-sampled after launch.
        bus.opA      = $urandom;
        bus.opB      = $urandom;
        bus.rdIn     = 5'($urandom_range(0, 31));
        bus.isSigned = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] hi, input logic [31:0] lo);
        int e0;
        bit ok;
        exp_q.push_back({32'(cyc + 1 + exp_lat(b, s)), rd, hi, lo});
        issue(s, a, b, rd, e0);
        check("busy_after_start", 64'(bus.busy), 64'd1);
        wait_idle(60, ok);
        check("completes_in_budget", 64'(ok), 64'd1);
        check("hold_lo", 64'(bus.busW),      64'(lo));
        check("hold_hi", 64'(bus.productHi), 64'(hi));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        bit ok;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.isSigned = 1'b0;
        bus.opA      = '0;
        bus.opB      = '0;
        bus.rdIn     = '0;
        #1;
        check("rst_busy",  64'(bus.busy),      64'd0);
        check("rst_done",  64'(bus.done),      64'd0);
        check("rst_regwr", 64'(bus.regWr),     64'd0);
        check("rst_rw",    64'(bus.Rw),        64'd0);
        check("rst_busw",  64'(bus.busW),      64'd0);
        check("rst_hi",    64'(bus.productHi), 64'd0);
        check("rst_state", 64'(bus.dbg_state), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back-to-back (start in the idle cycle after WB).
        run_op(1'b0, 32'd7,        32'd6,        5'd3,  32'h0000_0000, 32'd42);
        run_op(1'b1, 32'hFFFF_FFFD, 32'd5,       5'd4,  32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd5, 32'h0000_0001, 32'h0000_0000);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 32'h0000_0000);
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 5'd8, 32'h0000_0000, 32'd42);
        run_op(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFF, 32'h8000_0001);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(1'b1, 32'd0,        32'hFFFF_FFFB, 5'd2,  32'h0000_0000, 32'h0000_0000);
        run_op(1'b0, 32'h0000_1234, 32'd1,       5'd10, 32'h0000_0000, 32'h0000_1234);
        run_op(1'b0, 32'd5,        32'd0,        5'd11, 32'h0000_0000, 32'h0000_0000);
        run_op(1'b0, 32'd1,        32'h8000_0000, 5'd13, 32'h0000_0000, 32'h8000_0000);

        // Busy lockout: a second start sampled at E5 must be dropped.
        exp_q.push_back({32'(cyc + 1 + exp_lat(32'h10, 1'b0)), 5'd7, 32'h0000_0001, 32'h2345_6780});
        issue(1'b0, 32'h1234_5678, 32'h0000_0010, 5'd7, e0);
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.isSigned = 1'b0;
        bus.opA      = 32'd1;
        bus.opB      = 32'd1;
        bus.rdIn     = 5'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(60, ok);
        check("lockout_completes", 64'(ok), 64'd1);
        check("lockout_lo", 64'(bus.busW), 64'h2345_6780);
        repeat (40) @(negedge clk);  // any stray write from the dropped start shows in the monitor
        check("lockout_idle", 64'(bus.busy), 64'd0);

        // Reset mid-operation, between E10 and E11: no write may follow.
        issue(1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 5'd12, e0);
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_busy",  64'(bus.busy),      64'd0);
        check("midrst_regwr", 64'(bus.regWr),     64'd0);
        check("midrst_rw",    64'(bus.Rw),        64'd0);
        check("midrst_busw",  64'(bus.busW),      64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_stays_idle", 64'(bus.busy), 64'd0);
        run_op(1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 5'd14, 32'h0000_0000, 32'hFFFE_0001);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by time %0t, expected end of stimulus", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
